ram_stream_reader: RTL

Read-side master for `dual_port_RAM`. On a start command it drives the RAM read port (`i_raddr`/`o_rdata`) over a contiguous, wrapping address range. It returns the words on a valid/ready stream and absorbs the RAM read latency with an internal 3-entry buffer, so downstream backpressure never loses data. It is the counterpart of whatever fills the RAM through the write port, and it sits between the RAM and any streaming consumer.

---
 rtl/ram_stream_reader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-side master for a dual-port RAM.
// Walks a contiguous, wrapping address range on the RAM read port and
// returns the words on a valid/ready stream. A 3-entry buffer absorbs
// the 1-cycle RAM read latency so downstream backpressure never drops data.
// Optional feature macro: RAM_READER_LAST_EN adds the o_last port.
`timescale 1ns/1ps

module ram_stream_reader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_valid,
    input  logic              i_ready,
`ifdef RAM_READER_LAST_EN
    output logic              o_last,
`endif
    output logic [DATA_W-1:0] o_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;       // next address to issue
    logic [ADDR_W-1:0] raddr_reg;      // address presented to the RAM
    logic [LEN_W-1:0]  issue_cnt_reg;  // reads still to issue
    logic              inflight_reg;   // a read was issued last cycle
    logic [1:0]        count_reg;      // buffer occupancy, 0..3
    logic [1:0]        wr_ptr_reg;
    logic [1:0]        rd_ptr_reg;
    logic              busy_reg;
    logic              zero_done_reg;  // done pulse for a zero-length command
    logic [DATA_W-1:0] buf_reg [3];

    logic              issue;
    logic              push;
    logic              pop;
    logic              final_beat;
    logic              final_at_head;
    logic [LEN_W-1:0]  len_clamped;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign len_clamped = (i_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : i_len;

    // Issue only while the buffer plus the outstanding read leave a free slot.
    assign issue = (state_reg == RUN) &&
                   (({1'b0, count_reg} + {2'b00, inflight_reg}) < 3'd3);
    assign push  = inflight_reg;
    assign pop   = (count_reg != 2'd0) && i_ready;

    // All reads issued and captured, only the final word remains at the head.
    assign final_at_head = (state_reg == DRAIN) && (count_reg == 2'd1) && !inflight_reg;
    assign final_beat    = final_at_head && i_ready;

    assign o_busy  = busy_reg;
    assign o_done  = zero_done_reg | final_beat;
    assign o_raddr = raddr_reg;
    assign o_valid = (count_reg != 2'd0);

`ifdef RAM_READER_LAST_EN
    assign o_last = final_at_head;
`endif

    // Control FSM: command acceptance, read issue and completion.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            raddr_reg     <= '0;
            issue_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            zero_done_reg <= 1'b0;
        end else begin
            zero_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        if (len_clamped != '0) begin
                            addr_reg      <= i_base;
                            issue_cnt_reg <= len_clamped;
                            busy_reg      <= 1'b1;
                            state_reg     <= RUN;
                        end else begin
                            zero_done_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        raddr_reg     <= addr_reg;
                        addr_reg      <= addr_inc(addr_reg);
                        issue_cnt_reg <= issue_cnt_reg - 1'b1;
                        if (issue_cnt_reg == LEN_W'(1)) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (final_beat) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tag real reads, track buffer pointers and occupancy.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            inflight_reg <= 1'b0;
            count_reg    <= 2'd0;
            wr_ptr_reg   <= 2'd0;
            rd_ptr_reg   <= 2'd0;
        end else begin
            inflight_reg <= issue;
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    // One register per buffer entry, written when its slot is the push target.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_entry
            always_ff @(posedge clk or posedge i_rst) begin
                if (i_rst) begin
                    buf_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == 2'(gi))) begin
                    buf_reg[gi] <= i_rdata;
                end
            end
        end
    endgenerate

    // Head-of-buffer select.
    always_comb begin
        o_data = buf_reg[0];
        case (rd_ptr_reg)
            2'd1:    o_data = buf_reg[1];
            2'd2:    o_data = buf_reg[2];
            default: o_data = buf_reg[0];
        endcase
    end

endmodule
